// File: rtl/mvm3_ctrl_if.sv
// Stream handshake bundle for mvm3_ctrl: input words (s_valid/s_ready) and row results (m_valid/m_ready).
interface mvm3_ctrl_if;
  logic s_valid;
  logic s_ready;
  logic m_valid;
  logic m_ready;

  modport master (output s_valid, output m_ready, input s_ready, input m_valid);
  modport slave  (input s_valid, input m_ready, output s_ready, output m_valid);
endinterface

// File: rtl/mvm3_ctrl.sv
// Batch sequencer for the 3x3 matrix-vector multiply datapath: load A, load x, issue MACs per row, hand out rows.
// Optional status outputs (state_o, done_cnt) are built when MVM3_CTRL_STATUS_EN is defined.
module mvm3_ctrl #(
  parameter int M       = 3,
  parameter int N       = 3,
  parameter int MAC_LAT = 1,
  parameter int AW_A    = $clog2(M*N),
  parameter int AW_X    = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset,
  mvm3_ctrl_if.slave      hs,
  output logic            wr_en_a,
  output logic            wr_en_x,
  output logic [AW_A-1:0] addr_a,
  output logic [AW_X-1:0] addr_x,
  output logic            en_acc,
  output logic            clear_acc
`ifdef MVM3_CTRL_STATUS_EN
  ,
  output logic [2:0]      state_o,
  output logic [15:0]     done_cnt
`endif
);

  localparam int RW = (M > 1) ? $clog2(M) : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  localparam logic [AW_A-1:0] LAST_A   = AW_A'(M*N - 1);
  localparam logic [AW_A-1:0] LAST_X   = AW_A'(N - 1);
  localparam logic [RW-1:0]   LAST_ROW = RW'(M - 1);
  localparam logic [CW-1:0]   LAST_COL = CW'(N - 1);
  localparam logic [DW-1:0]   LAST_D   = DW'(MAC_LAT - 1);

  typedef enum logic [2:0] {
    LOAD_A  = 3'd0,
    LOAD_X  = 3'd1,
    COMPUTE = 3'd2,
    DRAIN   = 3'd3,
    OUTPUT  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [AW_A-1:0]    cnt_q, cnt_d;
  logic [RW-1:0]      row_q, row_d;
  logic [CW-1:0]      col_q, col_d;
  logic [DW-1:0]      dcnt_q, dcnt_d;
  logic [MAC_LAT-1:0] line_q, line_d;
  logic [MAC_LAT-1:0] tag_q, tag_d;

  logic            s_ready;
  logic            m_valid;
  logic            issue;
  logic            tag;
  logic [AW_A-1:0] rd_addr;

  assign hs.s_ready = s_ready;
  assign hs.m_valid = m_valid;
  assign rd_addr    = AW_A'(int'(row_q) * N + int'(col_q));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    row_d     = row_q;
    col_d     = col_q;
    dcnt_d    = dcnt_q;
    issue     = 1'b0;
    tag       = 1'b0;
    s_ready   = 1'b0;
    m_valid   = 1'b0;
    wr_en_a   = 1'b0;
    wr_en_x   = 1'b0;
    addr_a    = '0;
    addr_x    = '0;

    case (state_q)
      LOAD_A: begin
        s_ready = 1'b1;
        wr_en_a = hs.s_valid;
        addr_a  = cnt_q;
        if (hs.s_valid) begin
          if (cnt_q == LAST_A) begin
            state_d = LOAD_X;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + AW_A'(1);
          end
        end
      end
      LOAD_X: begin
        s_ready = 1'b1;
        wr_en_x = hs.s_valid;
        addr_x  = AW_X'(cnt_q);
        if (hs.s_valid) begin
          if (cnt_q == LAST_X) begin
            state_d = COMPUTE;
            cnt_d   = '0;
            row_d   = '0;
            col_d   = '0;
          end else begin
            cnt_d = cnt_q + AW_A'(1);
          end
        end
      end
      COMPUTE: begin
        issue  = 1'b1;
        tag    = (col_q == '0);
        addr_a = rd_addr;
        addr_x = AW_X'(col_q);
        if (col_q == LAST_COL) begin
          state_d = DRAIN;
          dcnt_d  = '0;
        end else begin
          col_d = col_q + CW'(1);
        end
      end
      DRAIN: begin
        addr_a = rd_addr;
        addr_x = AW_X'(col_q);
        if (dcnt_q == LAST_D) state_d = OUTPUT;
        else                  dcnt_d  = dcnt_q + DW'(1);
      end
      OUTPUT: begin
        m_valid = 1'b1;
        addr_a  = rd_addr;
        addr_x  = AW_X'(col_q);
        if (hs.m_ready) begin
          col_d = '0;
          if (row_q == LAST_ROW) begin
            state_d = LOAD_A;
            cnt_d   = '0;
            row_d   = '0;
          end else begin
            state_d = COMPUTE;
            row_d   = row_q + RW'(1);
          end
        end
      end
      default: state_d = LOAD_A;
    endcase

    // Issue pulse and first-term tag travel together so clear_acc lines up with its product.
    line_d[0] = issue;
    tag_d[0]  = tag;
    for (int unsigned i = 1; i < MAC_LAT; i++) begin
      line_d[i] = line_q[i-1];
      tag_d[i]  = tag_q[i-1];
    end

    en_acc    = line_q[MAC_LAT-1];
    clear_acc = line_q[MAC_LAT-1] & tag_q[MAC_LAT-1];

    if (reset) begin
      s_ready   = 1'b0;
      m_valid   = 1'b0;
      wr_en_a   = 1'b0;
      wr_en_x   = 1'b0;
      addr_a    = '0;
      addr_x    = '0;
      en_acc    = 1'b0;
      clear_acc = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LOAD_A;
      cnt_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      dcnt_q  <= '0;
      line_q  <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      col_q   <= col_d;
      dcnt_q  <= dcnt_d;
      line_q  <= line_d;
      tag_q   <= tag_d;
    end
  end

`ifdef MVM3_CTRL_STATUS_EN
  logic [15:0] done_cnt_q, done_cnt_d;

  always_comb begin
    done_cnt_d = done_cnt_q;
    if (m_valid && hs.m_ready) done_cnt_d = done_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) done_cnt_q <= '0;
    else       done_cnt_q <= done_cnt_d;
  end

  assign state_o  = state_q;
  assign done_cnt = done_cnt_q;
`endif

endmodule
